cosim_trace_buffer: RTL and testbench

COSIM_TRACE_BUFFER -- requirements
Module: cosim_trace_buffer

---
 rtl/cosim_trace_pkg.sv | 31 +++
 rtl/cosim_trace_fifo.sv | 72 +++++++
 rtl/cosim_trace_buffer.sv | 174 +++++++++++++++++
 tb/tb_cosim_trace_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cosim_trace_pkg
//  Description : Shared types and defaults for the co-simulation trace
//                buffer.
//                trace_entry_t holds one committed event as it sits in the
//                FIFO. The XLEN-wide fields are stored at C_MAX_XLEN bits so
//                the struct stays fixed-width. Narrower XLEN values are
//                zero-extended on write and truncated on read.
//  Revision    : 1.0  initial release
// ============================================================================
package cosim_trace_pkg;

  localparam int C_DEFAULT_DEPTH = 8;
  localparam int C_DEFAULT_XLEN  = 64;
  localparam int C_MAX_XLEN      = 64;

  typedef struct packed {
    logic                  valid_insn;
    logic [C_MAX_XLEN-1:0] iaddr;
    logic [31:0]           insn;
    logic                  exception;
    logic                  interrupt;
    logic [C_MAX_XLEN-1:0] cause;
    logic                  has_wdata;
    logic [C_MAX_XLEN-1:0] wdata;
    logic [63:0]           cycle;
  } trace_entry_t;

endpackage : cosim_trace_pkg
`default_nettype wire

// File: rtl/cosim_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cosim_trace_fifo
//  Description : Entry storage and pointers for the trace buffer.
//                The FIFO has two write ports and one read port.
//                Writing 0, 1 or 2 entries places i_wr_data0 at the write
//                pointer and i_wr_data1 at the slot after it. The caller
//                compacts lanes, so there are never holes.
//                The read side is first-word-fall-through: o_head always
//                shows the oldest entry.
//  Ports       : clock, reset (sync, active-low)
//                i_wr_cnt      entries to write this cycle (0..2)
//                i_wr_data0/1  entries for slot wptr / wptr+1
//                i_rd_en       pop head (caller guarantees non-empty)
//                o_head        oldest entry
//                o_level       occupancy, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module cosim_trace_fifo
  import cosim_trace_pkg::*;
#(
  parameter int DEPTH = C_DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               i_wr_cnt,
  input  trace_entry_t             i_wr_data0,
  input  trace_entry_t             i_wr_data1,
  input  logic                     i_rd_en,
  output trace_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  trace_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [LW-1:0]  r_level;
  logic [AW-1:0]  w_wptr_p1;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  assign w_wptr_p1 = r_wptr + AW'(1);

  // Storage carries no reset. Only the pointers and level decide validity.
  always_ff @(posedge clock) begin
    if (i_wr_cnt != 2'd0) begin
      r_mem[r_wptr] <= i_wr_data0;
    end
    if (i_wr_cnt == 2'd2) begin
      r_mem[w_wptr_p1] <= i_wr_data1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_wr_cnt);
      r_rptr  <= r_rptr + AW'(i_rd_en);
      r_level <= r_level + LW'(i_wr_cnt) - LW'(i_rd_en);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;

endmodule : cosim_trace_fifo
`default_nettype wire

// File: rtl/cosim_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cosim_trace_buffer
//  Description : Buffers the commit trace from a dual-issue core for a
//                co-simulation consumer.
//                - Each lane produces an event when it is valid, takes an
//                  exception, or takes an interrupt.
//                - Events are compacted into the FIFO in program order,
//                  lane 0 first.
//                - Every entry is stamped with a free-running cycle counter.
//                - A cycle whose events do not all fit is dropped as a
//                  whole. The drop sets the sticky overflow flag and adds
//                  the event count to a saturating drop counter.
//  Ports       : clock, reset (sync, active-low)
//                in_{0,1}_*    commit trace lanes, lane 0 older
//                out_ready     consumer pops head
//                out_valid     head entry present
//                out_*         head entry fields, out_cycle = enqueue stamp
//                level         occupancy
//                almost_full   fewer than two free slots
//                overflow      sticky drop flag
//                drop_count    dropped events, saturating at 0xFFFF
//  Revision    : 1.0  initial release
// ============================================================================
module cosim_trace_buffer
  import cosim_trace_pkg::*;
#(
  parameter int DEPTH = C_DEFAULT_DEPTH,
  parameter int XLEN  = C_DEFAULT_XLEN
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_0_valid,
  input  logic [XLEN-1:0]        in_0_iaddr,
  input  logic [31:0]            in_0_insn,
  input  logic                   in_0_exception,
  input  logic                   in_0_interrupt,
  input  logic [XLEN-1:0]        in_0_cause,
  input  logic                   in_0_has_wdata,
  input  logic [XLEN-1:0]        in_0_wdata,
  input  logic                   in_1_valid,
  input  logic [XLEN-1:0]        in_1_iaddr,
  input  logic [31:0]            in_1_insn,
  input  logic                   in_1_exception,
  input  logic                   in_1_interrupt,
  input  logic [XLEN-1:0]        in_1_cause,
  input  logic                   in_1_has_wdata,
  input  logic [XLEN-1:0]        in_1_wdata,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   out_valid_insn,
  output logic [XLEN-1:0]        out_iaddr,
  output logic [31:0]            out_insn,
  output logic                   out_exception,
  output logic                   out_interrupt,
  output logic [XLEN-1:0]        out_cause,
  output logic                   out_has_wdata,
  output logic [XLEN-1:0]        out_wdata,
  output logic [63:0]            out_cycle,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [15:0]            drop_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [63:0]   r_cycle;
  logic          r_overflow;
  logic [15:0]   r_drop_count;

  trace_entry_t  w_lane0;
  trace_entry_t  w_lane1;
  trace_entry_t  w_slot0;
  trace_entry_t  w_head;
  logic          w_evt0;
  logic          w_evt1;
  logic [1:0]    w_evt_cnt;
  logic [1:0]    w_enq_cnt;
  logic          w_deq;
  logic          w_drop;
  logic [LW:0]   w_space;
  logic [LW-1:0] w_level;
  logic [16:0]   w_drop_sum;

  // Build the lane entries. Fields are widened to the struct width.
  always_comb begin
    w_lane0            = '0;
    w_lane0.valid_insn = in_0_valid;
    w_lane0.iaddr      = C_MAX_XLEN'(in_0_iaddr);
    w_lane0.insn       = in_0_insn;
    w_lane0.exception  = in_0_exception;
    w_lane0.interrupt  = in_0_interrupt;
    w_lane0.cause      = C_MAX_XLEN'(in_0_cause);
    w_lane0.has_wdata  = in_0_has_wdata;
    w_lane0.wdata      = C_MAX_XLEN'(in_0_wdata);
    w_lane0.cycle      = r_cycle;

    w_lane1            = '0;
    w_lane1.valid_insn = in_1_valid;
    w_lane1.iaddr      = C_MAX_XLEN'(in_1_iaddr);
    w_lane1.insn       = in_1_insn;
    w_lane1.exception  = in_1_exception;
    w_lane1.interrupt  = in_1_interrupt;
    w_lane1.cause      = C_MAX_XLEN'(in_1_cause);
    w_lane1.has_wdata  = in_1_has_wdata;
    w_lane1.wdata      = C_MAX_XLEN'(in_1_wdata);
    w_lane1.cycle      = r_cycle;
  end

  assign w_evt0    = in_0_valid | in_0_exception | in_0_interrupt;
  assign w_evt1    = in_1_valid | in_1_exception | in_1_interrupt;
  assign w_evt_cnt = {1'b0, w_evt0} + {1'b0, w_evt1};

  // Compaction: a lone lane-1 event moves into the first write slot.
  // The second slot is only written when both lanes fire, so it is
  // always lane 1.
  assign w_slot0 = w_evt0 ? w_lane0 : w_lane1;

  assign out_valid = (w_level != '0);
  assign w_deq     = out_valid & out_ready;

  // A pop in the same cycle frees one more slot for this cycle's writes.
  // This lets a dual write at DEPTH-1 succeed together with a pop.
  assign w_space   = (LW+1)'(DEPTH) - {1'b0, w_level} + (LW+1)'(w_deq);
  assign w_drop    = ((LW+1)'(w_evt_cnt) > w_space);
  assign w_enq_cnt = w_drop ? 2'd0 : w_evt_cnt;

  assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_evt_cnt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cycle      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_drop) begin
        r_overflow   <= 1'b1;
        r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  cosim_trace_fifo #(
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_wr_cnt   (w_enq_cnt),
    .i_wr_data0 (w_slot0),
    .i_wr_data1 (w_lane1),
    .i_rd_en    (w_deq),
    .o_head     (w_head),
    .o_level    (w_level)
  );

  assign out_valid_insn = w_head.valid_insn;
  assign out_iaddr      = w_head.iaddr[XLEN-1:0];
  assign out_insn       = w_head.insn;
  assign out_exception  = w_head.exception;
  assign out_interrupt  = w_head.interrupt;
  assign out_cause      = w_head.cause[XLEN-1:0];
  assign out_has_wdata  = w_head.has_wdata;
  assign out_wdata      = w_head.wdata[XLEN-1:0];
  assign out_cycle      = w_head.cycle;

  assign level       = w_level;
  assign almost_full = ((LW+1)'(DEPTH) - {1'b0, w_level}) < (LW+1)'(2);
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;

endmodule : cosim_trace_buffer
`default_nettype wire

// File: tb/tb_cosim_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cosim_trace_buffer
//  Description : Directed self-checking bench for cosim_trace_buffer.
//                It uses DEPTH 8 and XLEN 64.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cosim_trace_buffer;

  localparam int DEPTH = 8;
  localparam int XLEN  = 64;

  logic            clock;
  logic            reset;
  logic            in_0_valid, in_0_exception, in_0_interrupt, in_0_has_wdata;
  logic [XLEN-1:0] in_0_iaddr, in_0_cause, in_0_wdata;
  logic [31:0]     in_0_insn;
  logic            in_1_valid, in_1_exception, in_1_interrupt, in_1_has_wdata;
  logic [XLEN-1:0] in_1_iaddr, in_1_cause, in_1_wdata;
  logic [31:0]     in_1_insn;
  logic            out_ready;
  logic            out_valid, out_valid_insn, out_exception, out_interrupt;
  logic            out_has_wdata;
  logic [XLEN-1:0] out_iaddr, out_cause, out_wdata;
  logic [31:0]     out_insn;
  logic [63:0]     out_cycle;
  logic [3:0]      level;
  logic            almost_full, overflow;
  logic [15:0]     drop_count;

  int n_checks = 0;
  int n_errors = 0;

  cosim_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_0_valid     (in_0_valid),
    .in_0_iaddr     (in_0_iaddr),
    .in_0_insn      (in_0_insn),
    .in_0_exception (in_0_exception),
    .in_0_interrupt (in_0_interrupt),
    .in_0_cause     (in_0_cause),
    .in_0_has_wdata (in_0_has_wdata),
    .in_0_wdata     (in_0_wdata),
    .in_1_valid     (in_1_valid),
    .in_1_iaddr     (in_1_iaddr),
    .in_1_insn      (in_1_insn),
    .in_1_exception (in_1_exception),
    .in_1_interrupt (in_1_interrupt),
    .in_1_cause     (in_1_cause),
    .in_1_has_wdata (in_1_has_wdata),
    .in_1_wdata     (in_1_wdata),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_valid_insn (out_valid_insn),
    .out_iaddr      (out_iaddr),
    .out_insn       (out_insn),
    .out_exception  (out_exception),
    .out_interrupt  (out_interrupt),
    .out_cause      (out_cause),
    .out_has_wdata  (out_has_wdata),
    .out_wdata      (out_wdata),
    .out_cycle      (out_cycle),
    .level          (level),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_0_valid = 0; in_0_exception = 0; in_0_interrupt = 0; in_0_has_wdata = 0;
    in_0_iaddr = '0; in_0_cause = '0; in_0_wdata = '0; in_0_insn = '0;
    in_1_valid = 0; in_1_exception = 0; in_1_interrupt = 0; in_1_has_wdata = 0;
    in_1_iaddr = '0; in_1_cause = '0; in_1_wdata = '0; in_1_insn = '0;
  endtask

  task automatic set_lane0(input logic v, input logic exc,
                           input logic [63:0] ia, input logic [31:0] ins,
                           input logic [63:0] cause);
    in_0_valid = v; in_0_exception = exc; in_0_iaddr = ia;
    in_0_insn = ins; in_0_cause = cause;
  endtask

  task automatic set_lane1(input logic v, input logic [63:0] ia,
                           input logic [31:0] ins);
    in_1_valid = v; in_1_iaddr = ia; in_1_insn = ins;
  endtask

  initial begin
    clear_inputs();
    out_ready = 0;
    reset     = 0;
    tick();
    tick();
    check_eq("rst_level", 64'(level), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_drop_count", 64'(drop_count), 64'd0);
    check_eq("rst_almost_full", 64'(almost_full), 64'd0);

    // Counter value is 0 in this cycle and advances once per tick.
    reset = 1;
    for (int i = 0; i < 5; i++) tick();
    set_lane0(1, 0, 64'h8000_0000, 32'h0000_0297, 64'd0);
    check_eq("no_bypass", 64'(out_valid), 64'd0);
    tick();
    clear_inputs();
    check_eq("lat_out_valid", 64'(out_valid), 64'd1);
    check_eq("lat_iaddr", out_iaddr, 64'h8000_0000);
    check_eq("lat_cycle", out_cycle, 64'd5);
    check_eq("lat_level", 64'(level), 64'd1);
    check_eq("lat_valid_insn", 64'(out_valid_insn), 64'd1);
    tick();
    check_eq("hold_iaddr", out_iaddr, 64'h8000_0000);
    out_ready = 1;
    tick();
    out_ready = 0;
    check_eq("drain_level", 64'(level), 64'd0);

    // A lone lane-1 event is compacted into the first slot.
    set_lane1(1, 64'h100, 32'h0000_0013);
    tick();
    clear_inputs();
    check_eq("l1only_level", 64'(level), 64'd1);
    check_eq("l1only_insn", 64'(out_insn), 64'h13);
    set_lane0(1, 0, 64'h200, 32'h0000_000A, 64'd0);
    set_lane1(1, 64'h204, 32'h0000_000B);
    tick();
    clear_inputs();
    check_eq("dual_level", 64'(level), 64'd3);
    out_ready = 1;
    check_eq("order0", out_iaddr, 64'h100);
    tick();
    check_eq("order1", out_iaddr, 64'h200);
    tick();
    check_eq("order2", out_iaddr, 64'h204);
    check_eq("order2_insn", 64'(out_insn), 64'h0B);
    tick();
    out_ready = 0;
    check_eq("order_empty", 64'(out_valid), 64'd0);

    // An exception-only event is enqueued with out_valid_insn clear.
    set_lane0(0, 1, 64'h300, 32'h0, 64'd2);
    tick();
    clear_inputs();
    check_eq("exc_valid_insn", 64'(out_valid_insn), 64'd0);
    check_eq("exc_exception", 64'(out_exception), 64'd1);
    check_eq("exc_cause", out_cause, 64'd2);
    out_ready = 1;
    tick();
    out_ready = 0;
    check_eq("exc_drain", 64'(level), 64'd0);

    // Fill the buffer with dual events, then overflow it.
    for (int i = 0; i < 4; i++) begin
      set_lane0(1, 0, 64'h1000 + 64'(16*i), 32'h1, 64'd0);
      set_lane1(1, 64'h1008 + 64'(16*i), 32'h2);
      tick();
      if (i == 2) begin
        check_eq("fill6_level", 64'(level), 64'd6);
        check_eq("fill6_af", 64'(almost_full), 64'd0);
      end
    end
    check_eq("full_level", 64'(level), 64'd8);
    check_eq("full_af", 64'(almost_full), 64'd1);
    check_eq("full_ovf_clear", 64'(overflow), 64'd0);
    tick();
    check_eq("ovf_level", 64'(level), 64'd8);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    check_eq("ovf_drop_count", 64'(drop_count), 64'd2);
    check_eq("ovf_head", out_iaddr, 64'h1000);

    // Pop one entry with no new events.
    clear_inputs();
    out_ready = 1;
    tick();
    out_ready = 0;
    check_eq("pop_level", 64'(level), 64'd7);
    check_eq("pop_af", 64'(almost_full), 64'd1);

    // At level 7 with no pop, a dual event has space 1 and is dropped whole.
    set_lane0(1, 0, 64'h2000, 32'h3, 64'd0);
    set_lane1(1, 64'h2004, 32'h4);
    tick();
    check_eq("aon_level", 64'(level), 64'd7);
    check_eq("aon_drop_count", 64'(drop_count), 64'd4);

    // At level 7 with a pop, a dual event has space 2 and both are kept.
    out_ready = 1;
    tick();
    out_ready = 0;
    clear_inputs();
    check_eq("l7pop_level", 64'(level), 64'd8);
    check_eq("l7pop_drop_count", 64'(drop_count), 64'd4);
    check_eq("l7pop_ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-operation; inputs driven during reset must be ignored.
    set_lane0(1, 0, 64'h3000, 32'h5, 64'd0);
    set_lane1(1, 64'h3004, 32'h6);
    reset = 0;
    tick();
    clear_inputs();
    reset = 1;
    check_eq("mrst_level", 64'(level), 64'd0);
    check_eq("mrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mrst_overflow", 64'(overflow), 64'd0);
    check_eq("mrst_drop_count", 64'(drop_count), 64'd0);
    for (int i = 0; i < 3; i++) tick();
    set_lane0(1, 0, 64'h4000, 32'h7, 64'd0);
    tick();
    clear_inputs();
    check_eq("mrst_cycle", out_cycle, 64'd3);
    check_eq("mrst_iaddr", out_iaddr, 64'h4000);
    check_eq("mrst_level1", 64'(level), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cosim_trace_buffer
`default_nettype wire
